// File: rtl/network_pkg.sv
// ---------------------------------------------------------------------------
// network_pkg
// Shared definitions for the inference-core launcher and its consumers:
//   - state_e       : launcher FSM encoding (IDLE=0, START=1, WAIT=2, HOLD=3)
//   - RESULT_W_DEF  : default width of the core result / captured label
//   - CNT_W_DEF     : default width of the latency and run counters
//   - TIMEOUT_LABEL : label value reported when a run is aborted by timeout
// ---------------------------------------------------------------------------
package network_pkg;

  localparam int RESULT_W_DEF = 32;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Consumers compare res_label against this to recognise an aborted run.
  localparam logic [RESULT_W_DEF-1:0] TIMEOUT_LABEL = '1;

endpackage : network_pkg

// File: rtl/network_launcher_if.sv
// ---------------------------------------------------------------------------
// network_launcher_if
// Bundles the three channels around the launcher:
//   request : req_valid / req_ready          (controller -> launcher)
//   core    : core_start, core_done, core_return (launcher <-> inference core)
//   result  : res_valid / res_ready, res_label, res_timeout, res_cycles
//             (launcher -> downstream)
// Modports:
//   master : the launcher side (drives start, req_ready and the result channel)
//   slave  : the environment side (controller, core and result consumer)
// ---------------------------------------------------------------------------
interface network_launcher_if #(
  parameter int RESULT_W = network_pkg::RESULT_W_DEF,
  parameter int CNT_W    = network_pkg::CNT_W_DEF
);

  logic                req_valid;
  logic                req_ready;
  logic                core_start;
  logic                core_done;
  logic [RESULT_W-1:0] core_return;
  logic                res_valid;
  logic                res_ready;
  logic [RESULT_W-1:0] res_label;
  logic                res_timeout;
  logic [CNT_W-1:0]    res_cycles;

  modport master (
    input  req_valid,
    output req_ready,
    output core_start,
    input  core_done,
    input  core_return,
    output res_valid,
    input  res_ready,
    output res_label,
    output res_timeout,
    output res_cycles
  );

  modport slave (
    output req_valid,
    input  req_ready,
    input  core_start,
    output core_done,
    output core_return,
    input  res_valid,
    output res_ready,
    input  res_label,
    input  res_timeout,
    input  res_cycles
  );

endinterface : network_launcher_if

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at 2^W-1 instead of wrapping.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low reset (count -> 0)
//   clear  : synchronous clear, has priority over inc
//   inc    : advance by one unless already saturated
//   count  : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/network_launcher.sv
// ---------------------------------------------------------------------------
// network_launcher
// Initiator for the inference core's start/done/return interface. Accepts a
// run request, pulses core_start for one cycle, waits for core_done (or a
// timeout), captures the label and latency, and holds them on the result
// channel until accepted. Counts delivered results.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous, active-low reset
//   bus       : request / core / result channels (master side)
//   busy      : launcher is not IDLE
//   run_count : delivered results since reset, saturating
// Latency convention: the START cycle is cycle 0; a done sampled k cycles
// later reports res_cycles = k.
// ---------------------------------------------------------------------------
module network_launcher
  import network_pkg::*;
#(
  parameter int          RESULT_W       = RESULT_W_DEF,
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  network_launcher_if.master   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     run_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam longint unsigned   CNT_MAX_L = (64'd1 << CNT_W) - 64'd1;

  // The latency counter reaches TIMEOUT_CYCLES-1 only if that value fits in
  // CNT_W bits; a larger limit can never fire, so it behaves as disabled.
  localparam bit TIMEOUT_EN =
    (TIMEOUT_CYCLES != 0) && ((64'(TIMEOUT_CYCLES) - 64'd1) <= CNT_MAX_L);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_SAT  =
    (64'(TIMEOUT_CYCLES) > CNT_MAX_L) ? CNT_MAX : CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [RESULT_W-1:0] label_q, label_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                timeout_q, timeout_d;

  logic                lat_clear, lat_inc, run_inc;
  logic [CNT_W-1:0]    lat_count;

  sat_counter #(.W(CNT_W)) u_lat_counter (
    .clock (clock),
    .reset (reset),
    .clear (lat_clear),
    .inc   (lat_inc),
    .count (lat_count)
  );

  sat_counter #(.W(CNT_W)) u_run_counter (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (run_inc),
    .count (run_count)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    label_d   = label_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    lat_clear = 1'b0;
    lat_inc   = 1'b0;
    run_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = START;
        end
      end

      START: begin
        // core_done is deliberately not looked at here.
        lat_clear = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        lat_inc = 1'b1;
        // Done is checked first so it wins over a coincident timeout.
        if (bus.core_done) begin
          label_d   = bus.core_return;
          cycles_d  = (lat_count == CNT_MAX) ? CNT_MAX : lat_count + 1'b1;
          timeout_d = 1'b0;
          state_d   = HOLD;
        end else if (TIMEOUT_EN && (lat_count == TIMEOUT_LAST)) begin
          label_d   = {RESULT_W{1'b1}};  // same pattern as TIMEOUT_LABEL
          cycles_d  = TIMEOUT_SAT;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (bus.res_ready) begin
          run_inc = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: only the control and result registers are reset; they are plain
  // flops, so clearing them here costs nothing and a pending result cannot
  // leak past a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      label_q   <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      label_q   <= label_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  // Handshake outputs are decoded from state; req_ready is additionally
  // gated so no request is acknowledged while reset is held.
  assign bus.req_ready   = reset && (state_q == IDLE);
  assign bus.core_start  = (state_q == START);
  assign bus.res_valid   = (state_q == HOLD);
  assign bus.res_label   = label_q;
  assign bus.res_cycles  = cycles_q;
  assign bus.res_timeout = timeout_q;
  assign busy            = (state_q != IDLE);

endmodule : network_launcher

// File: tb/tb_network_launcher.sv
// ---------------------------------------------------------------------------
// tb_network_launcher
// Self-checking bench for network_launcher with TIMEOUT_CYCLES = 16.
// A reference model computes each run's expected result directly from the
// rules: a done at cycle k in 1..TO returns (label, k, 0); anything else
// returns (all-ones, TO, 1). Delivered results are counted in exp_runs.
// ---------------------------------------------------------------------------
module tb_network_launcher;
  import network_pkg::*;

  localparam int RW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          busy;
  logic [CW-1:0] run_count;

  int n_cmp    = 0;
  int n_fail   = 0;
  int exp_runs = 0;

  network_launcher_if #(.RESULT_W(RW), .CNT_W(CW)) bus ();

  network_launcher #(
    .RESULT_W       (RW),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.master),
    .busy      (busy),
    .run_count (run_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete run. k = cycle (after START) at which the core raises done;
  // k = 0 means the core never answers. bp = cycles of backpressure in HOLD,
  // late_at = backpressure cycle carrying a stray core_done (0 = none),
  // start_noise = raise core_done during START, hold_req = keep req_valid
  // asserted while the result is held.
  task automatic do_run(input logic [31:0] lbl, input int k, input int bp,
                        input int late_at, input bit start_noise, input bit hold_req);
    int           cyc;
    int           exp_cyc;
    logic [31:0]  exp_lbl;
    logic         exp_to;

    if (k >= 1 && k <= TO) begin
      exp_lbl = lbl;   exp_cyc = k;  exp_to = 1'b0;
    end else begin
      exp_lbl = TIMEOUT_LABEL; exp_cyc = TO; exp_to = 1'b1;
    end

    check("idle_req_ready", bus.req_ready, 1);
    check("idle_busy", busy, 0);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("start_pulse", bus.core_start, 1);
    check("start_busy", busy, 1);
    check("start_req_ready", bus.req_ready, 0);

    cyc = 0;
    while (!bus.res_valid && cyc < 200) begin
      bus.core_done   = (cyc == 0) ? start_noise : (cyc == k);
      bus.core_return = (cyc == k) ? lbl : $urandom;
      tick();
      cyc++;
      if (cyc == 1) check("start_one_cycle", bus.core_start, 0);
    end
    bus.core_done = 1'b0;

    check("hold_entry_cycle", cyc, exp_cyc + 1);
    check("res_valid", bus.res_valid, 1);
    check("res_label", bus.res_label, exp_lbl);
    check("res_cycles", bus.res_cycles, exp_cyc);
    check("res_timeout", bus.res_timeout, exp_to);

    for (int i = 1; i <= bp; i++) begin
      bus.req_valid   = hold_req;
      bus.core_done   = (i == late_at);
      bus.core_return = $urandom;
      tick();
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_label", bus.res_label, exp_lbl);
      check("bp_cycles", bus.res_cycles, exp_cyc);
      check("bp_timeout", bus.res_timeout, exp_to);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_no_start", bus.core_start, 0);
    end

    bus.core_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    if (exp_runs < 65535) exp_runs++;
    check("run_count", run_count, exp_runs);
    check("done_res_valid", bus.res_valid, 0);
    check("done_busy", busy, 0);
    check("done_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.res_ready   = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_return = '0;
    reset           = 1'b0;

    // Reset held for three edges.
    repeat (3) tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_run_count", run_count, 0);
    check("rst_res_label", bus.res_label, 0);
    check("rst_res_cycles", bus.res_cycles, 0);
    check("rst_res_timeout", bus.res_timeout, 0);
    reset = 1'b1;
    #1;
    check("rel_req_ready", bus.req_ready, 1);
    check("rel_busy", busy, 0);
    tick();

    // Basic run: label 7, done five cycles after start.
    do_run(32'd7, 5, 0, 0, 1'b0, 1'b0);
    // Core never answers; stray done three cycles into HOLD.
    do_run(32'h1234_5678, 0, 4, 3, 1'b0, 1'b0);
    // Backpressure with a request pending throughout.
    do_run(32'd3, 4, 10, 0, 1'b0, 1'b1);
    // Done on exactly the timeout cycle, plus a done during START.
    do_run(32'd9, TO, 0, 0, 1'b1, 1'b0);
    // Done one cycle too late: timeout.
    do_run(32'd11, TO + 1, 0, 0, 1'b0, 1'b0);
    // Fastest possible answer.
    do_run(32'hCAFE_0001, 1, 1, 0, 1'b0, 1'b0);

    // Reset while waiting on the core.
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", busy, 1);
    reset = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_run_count", run_count, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_core_start", bus.core_start, 0);
    reset    = 1'b1;
    exp_runs = 0;
    bus.core_done   = 1'b1;
    bus.core_return = 32'hDEAD_BEEF;
    tick();
    bus.core_done = 1'b0;
    check("late_done_busy", busy, 0);
    check("late_done_res_valid", bus.res_valid, 0);
    check("late_done_run_count", run_count, 0);
    do_run(32'hA5A5_A5A5, 3, 1, 0, 1'b0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 12; r++) begin
      do_run($urandom, int'($urandom_range(20, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)));
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_network_launcher

// File: doc/network_launcher.md
Name: network_launcher

Overview:
Initiator for the inference core's start/done/return interface.
- Accepts a run request over a valid/ready handshake.
- Pulses the core's start input and waits for the core's done pulse.
- Captures the 32-bit predicted label and the run latency, then presents them downstream on a valid/ready result channel.
- Sits between the system controller (or test sequencer) and the inference core; adds timeout protection and a run counter.

Parameters:
RESULT_W, 32, width of core_return / res_label
CNT_W, 16, width of latency and run counters
TIMEOUT_CYCLES, 4096, WAIT-state cycle limit before abort; 0 disables timeout

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_valid  input  1  run request
req_ready  output  1  launcher can accept a request
core_start  output  1  start pulse to inference core
core_done  input  1  one-cycle done pulse from core
core_return  input  RESULT_W  core result, valid in the core_done cycle
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_label  output  RESULT_W  captured label; all-ones on timeout
res_timeout  output  1  result was produced by timeout
res_cycles  output  CNT_W  cycles from core_start to core_done, saturating
busy  output  1  state != IDLE
run_count  output  CNT_W  completed (delivered) results, saturating

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE.
  - core_start, res_valid, res_timeout, busy = 0; res_label, res_cycles, run_count = 0.
  - req_ready is forced 0 while reset is low.
- States: IDLE, START, WAIT, HOLD; all outputs are registered or decoded from state.
- IDLE:
  - req_ready=1.
  - req_valid=1 → START. The handshake completes in that cycle.
- START:
  - core_start=1 for exactly one cycle.
  - Latency counter is cleared to 0 → WAIT.
  - core_done in this cycle is ignored.
- WAIT:
  - Latency counter increments each cycle, saturating at 2^CNT_W-1.
  - core_done=1: res_label←core_return, res_cycles←counter+1 (saturated), res_timeout←0 → HOLD.
  - Otherwise, if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: res_label←all-ones, res_cycles←TIMEOUT_CYCLES (saturated), res_timeout←1 → HOLD.
  - core_done and the timeout condition in the same cycle: done wins, res_timeout=0.
- HOLD:
  - res_valid=1; res_label, res_timeout and res_cycles are stable while res_valid=1 and res_ready=0.
  - res_ready=1: run_count increments (saturating) → IDLE.
  - req_valid is not accepted in HOLD; minimum one IDLE cycle between runs.
- Latency convention: START is cycle 0. Done sampled k cycles after the START cycle gives res_cycles=k. Minimum request-to-start is 1 cycle (core_start high the cycle after acceptance).
- core_done in IDLE or HOLD (late done after a timeout, or spurious) is ignored and has no state effect.
- A timed-out core is not recovered by this block; the system resets it.
- Reset mid-operation (any state) returns to IDLE next edge with all outputs at reset values. A pending result is discarded and run_count is cleared.
- busy=1 in START, WAIT, HOLD.

Decomposition:
- Shared package network_pkg:
  - state encoding (IDLE=0, START=1, WAIT=2, HOLD=3);
  - RESULT_W default;
  - TIMEOUT_LABEL constant (all-ones) used by consumers to recognise aborts.
- One sub-module is natural: sat_counter (parameter W; inputs clear, inc; output count). It saturates at 2^W-1 and is instantiated twice: latency and run_count.

Test Plan:
- Reset held low 3 cycles, then released → all outputs 0. req_ready=1 from the first cycle after release; busy=0.
- req_valid pulse. Core model returns 32'd7 with done 5 cycles after core_start → core_start high exactly 1 cycle; res_valid=1, res_label=7, res_cycles=5, res_timeout=0. res_ready=1 → run_count=1, back to IDLE.
- TIMEOUT_CYCLES=16, core never asserts done → after 16 WAIT cycles res_valid=1, res_label=32'hFFFF_FFFF, res_timeout=1, res_cycles=16. A late core_done 3 cycles later is ignored.
- Backpressure: result label 3, res_ready held 0 for 10 cycles with req_valid=1 throughout → res_label stable at 3, req_ready=0, no second core_start. res_ready=1 → IDLE, then the next run starts.
- TIMEOUT_CYCLES=8, core_done with core_return=9 exactly on the 8th WAIT cycle (timeout cycle) → res_label=9, res_timeout=0.
- reset driven low while in WAIT → next edge IDLE, res_valid=0, run_count=0. core_done arriving after release is ignored; next req_valid launches normally.
